// File: rtl/win_timing_ctrl_pkg.sv
// Shared definitions for the windowed raster timing controller:
// FSM encoding, default 720p timing, alignment-delay geometry.
package win_timing_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_WAIT_LINE = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam int TIM_H_SYNC  = 40;
    localparam int TIM_H_BACK  = 220;
    localparam int TIM_H_DISP  = 1280;
    localparam int TIM_H_FRONT = 110;
    localparam int TIM_H_TOTAL = 1650;

    localparam int TIM_V_SYNC  = 5;
    localparam int TIM_V_BACK  = 20;
    localparam int TIM_V_DISP  = 720;
    localparam int TIM_V_FRONT = 5;
    localparam int TIM_V_TOTAL = 750;

    localparam int DLY_WIDTH = 7;
    localparam int DLY_DEPTH = 2;

    // Half-open interval test [lo, hi) on counter values.
    function automatic logic in_window(input logic [10:0] val,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/win_timing_ctrl_delay.sv
// Fixed-depth register pipeline used to align the rebuilt raster flags
// with line-buffer read data.
module sig_delay_line
    import win_timing_ctrl_pkg::*;
#(
    parameter int WIDTH = DLY_WIDTH,
    parameter int DEPTH = DLY_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    // Shift register; stage 0 captures the input each clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= {WIDTH{1'b0}};
            end
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/win_timing_ctrl.sv
// Raster timing regenerator: locks to upstream vsync/hsync, drives line-buffer
// read enables, and emits window-aligned sync/valid/border flags.
module win_timing_ctrl
    import win_timing_ctrl_pkg::*;
#(
    parameter int H_SYNC  = TIM_H_SYNC,
    parameter int H_BACK  = TIM_H_BACK,
    parameter int H_DISP  = TIM_H_DISP,
    parameter int H_FRONT = TIM_H_FRONT,
    parameter int H_TOTAL = TIM_H_TOTAL,
    parameter int V_SYNC  = TIM_V_SYNC,
    parameter int V_BACK  = TIM_V_BACK,
    parameter int V_DISP  = TIM_V_DISP,
    parameter int V_FRONT = TIM_V_FRONT,
    parameter int V_TOTAL = TIM_V_TOTAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        err_clr,
    input  logic        pre_img_vsync,
    input  logic        pre_img_hsync,
    output logic        lb1_rd_en,
    output logic        lb2_rd_en,
    output logic        out_vsync,
    output logic        out_hsync,
    output logic        out_valid,
    output logic        top_edge,
    output logic        bottom_edge,
    output logic        left_edge,
    output logic        right_edge,
    output logic [10:0] h_cnt,
    output logic [9:0]  v_cnt,
    output logic [1:0]  state,
    output logic        frame_err
);

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
    localparam logic [10:0] H_ACT_LO    = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_HI    = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] H_ACT_LAST  = 11'(H_SYNC + H_BACK + H_DISP - 1);
    localparam logic [10:0] V_ACT_LO    = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_HI    = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] V_ACT_LAST  = 11'(V_SYNC + V_BACK + V_DISP - 1);

    // An inconsistent timing set keeps every raster output quiet rather
    // than emitting a malformed picture.
    localparam logic TIMING_OK =
        (H_SYNC + H_BACK + H_DISP + H_FRONT == H_TOTAL) &&
        (V_SYNC + V_BACK + V_DISP + V_FRONT == V_TOTAL) &&
        (H_TOTAL > 0) && (H_TOTAL <= 2047) &&
        (V_TOTAL > 0) && (V_TOTAL <= 1023);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [10:0] r_h_cnt;
    logic [10:0] w_h_nxt;
    logic [9:0]  r_v_cnt;
    logic [9:0]  w_v_nxt;
    logic        r_vs_prev;
    logic        r_hs_prev;
    logic        r_frame_err;
    logic        w_err_set;
    logic        w_vs_rise;
    logic        w_hs_rise;
    logic        w_h_wrap;
    logic        w_eof;
    logic        w_run;
    logic [10:0] w_v_ext;
    logic        w_raw_valid;
    logic        w_raw_hsync;
    logic        w_raw_vsync;
    logic [6:0]  w_raw_bus;
    logic [6:0]  w_dly_bus;

    assign w_vs_rise = pre_img_vsync & ~r_vs_prev;
    assign w_hs_rise = pre_img_hsync & ~r_hs_prev;
    assign w_h_wrap  = (r_h_cnt == H_LAST);
    assign w_eof     = w_h_wrap && (r_v_cnt == V_LAST);

    // Next-state and next-counter decode; counters are zero outside RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = 11'd0;
        w_v_nxt     = 10'd0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) w_state_nxt = ST_ARMED;
                else        w_state_nxt = ST_IDLE;
            end
            ST_ARMED: begin
                if (!enable)        w_state_nxt = ST_IDLE;
                else if (w_vs_rise) w_state_nxt = ST_WAIT_LINE;
                else                w_state_nxt = ST_ARMED;
            end
            ST_WAIT_LINE: begin
                if (!enable)        w_state_nxt = ST_IDLE;
                else if (w_hs_rise) w_state_nxt = ST_RUN;
                else                w_state_nxt = ST_WAIT_LINE;
            end
            ST_RUN: begin
                // A new vsync always resyncs; it is only an error mid-frame.
                if (w_vs_rise) begin
                    w_state_nxt = ST_WAIT_LINE;
                    w_err_set   = ~w_eof;
                end else if (w_eof) begin
                    if (enable) w_state_nxt = ST_ARMED;
                    else        w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                    if (w_h_wrap) begin
                        w_h_nxt = 11'd0;
                        w_v_nxt = r_v_cnt + 10'd1;
                    end else begin
                        w_h_nxt = r_h_cnt + 11'd1;
                        w_v_nxt = r_v_cnt;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, counters, sync history and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_h_cnt     <= 11'd0;
            r_v_cnt     <= 10'd0;
            r_vs_prev   <= 1'b0;
            r_hs_prev   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_h_cnt   <= w_h_nxt;
            r_v_cnt   <= w_v_nxt;
            r_vs_prev <= pre_img_vsync;
            r_hs_prev <= pre_img_hsync;
            if (w_err_set)    r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;
            else              r_frame_err <= r_frame_err;
        end
    end

    assign w_run       = (r_state == ST_RUN) && TIMING_OK;
    assign w_v_ext     = {1'b0, r_v_cnt};
    assign w_raw_valid = w_run && in_window(r_h_cnt, H_ACT_LO, H_ACT_HI)
                               && in_window(w_v_ext, V_ACT_LO, V_ACT_HI);
    assign w_raw_hsync = w_run && (r_h_cnt < H_SYNC_END);
    assign w_raw_vsync = w_run && (r_v_cnt < V_SYNC_END);

    assign lb1_rd_en = w_raw_valid;
    assign lb2_rd_en = w_raw_valid && (w_v_ext > V_ACT_LO);

    assign w_raw_bus = {w_raw_vsync,
                        w_raw_hsync,
                        w_raw_valid,
                        w_raw_valid && (w_v_ext == V_ACT_LO),
                        w_raw_valid && (w_v_ext == V_ACT_LAST),
                        w_raw_valid && (r_h_cnt == H_ACT_LO),
                        w_raw_valid && (r_h_cnt == H_ACT_LAST)};

    sig_delay_line #(
        .WIDTH (DLY_WIDTH),
        .DEPTH (DLY_DEPTH)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_raw_bus),
        .o_q   (w_dly_bus)
    );

    assign out_vsync   = w_dly_bus[6];
    assign out_hsync   = w_dly_bus[5];
    assign out_valid   = w_dly_bus[4];
    assign top_edge    = w_dly_bus[3];
    assign bottom_edge = w_dly_bus[2];
    assign left_edge   = w_dly_bus[1];
    assign right_edge  = w_dly_bus[0];

    assign h_cnt     = r_h_cnt;
    assign v_cnt     = r_v_cnt;
    assign state     = r_state;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_win_timing_ctrl.sv
// Directed plus random bench for win_timing_ctrl on a reduced 14x7 raster,
// checked against a frame-position reference model.
module tb_win_timing_ctrl;

    localparam int HS = 2, HB = 2, HD = 8, HF = 2, HT = 14;
    localparam int VS = 1, VB = 1, VD = 4, VF = 1, VT = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        err_clr = 1'b0;
    logic        pre_img_vsync = 1'b0;
    logic        pre_img_hsync = 1'b0;
    logic        lb1_rd_en, lb2_rd_en, out_vsync, out_hsync, out_valid;
    logic        top_edge, bottom_edge, left_edge, right_edge;
    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic [1:0]  state;
    logic        frame_err;

    win_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .err_clr(err_clr),
        .pre_img_vsync(pre_img_vsync), .pre_img_hsync(pre_img_hsync),
        .lb1_rd_en(lb1_rd_en), .lb2_rd_en(lb2_rd_en),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .out_valid(out_valid),
        .top_edge(top_edge), .bottom_edge(bottom_edge),
        .left_edge(left_edge), .right_edge(right_edge),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .state(state), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: mode 0..3, linear pixel position within the frame.
    int         m_mode, m_pos;
    logic       m_err, m_vs_prev, m_hs_prev;
    logic [6:0] m_d1, m_d2;

    int smp, first_lb1, first_ov;
    int n_lb1, n_lb2, n_ov, n_top, n_bot, n_left, n_right;

    function automatic logic [6:0] raw_of(input int mode, input int pos);
        int   h, v;
        logic run, val;
        h   = pos % HT;
        v   = pos / HT;
        run = (mode == 3);
        val = run && (h >= HS + HB) && (h < HS + HB + HD)
                  && (v >= VS + VB) && (v < VS + VB + VD);
        return {run && (v < VS), run && (h < HS), val,
                val && (v == VS + VB), val && (v == VS + VB + VD - 1),
                val && (h == HS + HB), val && (h == HS + HB + HD - 1)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_err = 1'b0;
        m_vs_prev = 1'b0; m_hs_prev = 1'b0;
        m_d1 = 7'd0; m_d2 = 7'd0;
    endtask

    task automatic check_all();
        logic [6:0] r;
        r = raw_of(m_mode, m_pos);
        chk("state", state, m_mode);
        chk("h_cnt", h_cnt, m_pos % HT);
        chk("v_cnt", v_cnt, m_pos / HT);
        chk("lb1_rd_en", lb1_rd_en, r[4]);
        chk("lb2_rd_en", lb2_rd_en, r[4] && ((m_pos / HT) > VS + VB));
        chk("out_vsync", out_vsync, m_d2[6]);
        chk("out_hsync", out_hsync, m_d2[5]);
        chk("out_valid", out_valid, m_d2[4]);
        chk("top_edge", top_edge, m_d2[3]);
        chk("bottom_edge", bottom_edge, m_d2[2]);
        chk("left_edge", left_edge, m_d2[1]);
        chk("right_edge", right_edge, m_d2[0]);
        chk("frame_err", frame_err, m_err);
    endtask

    task automatic clear_tally();
        first_lb1 = -1; first_ov = -1;
        n_lb1 = 0; n_lb2 = 0; n_ov = 0;
        n_top = 0; n_bot = 0; n_left = 0; n_right = 0;
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input logic en, input logic vs, input logic hs, input logic clr);
        logic vr, hr, eof, ne;
        int   nm, np;
        enable = en; pre_img_vsync = vs; pre_img_hsync = hs; err_clr = clr;
        vr  = vs && !m_vs_prev;
        hr  = hs && !m_hs_prev;
        eof = (m_pos == HT * VT - 1);
        nm  = m_mode; np = 0; ne = m_err;
        case (m_mode)
            0: if (en) nm = 1;
            1: if (!en) nm = 0; else if (vr) nm = 2;
            2: if (!en) nm = 0; else if (hr) nm = 3;
            default: begin
                if (vr) nm = 2;
                else if (eof) nm = en ? 1 : 0;
                else np = m_pos + 1;
            end
        endcase
        if (m_mode == 3 && vr && !eof) ne = 1'b1;
        else if (clr) ne = 1'b0;
        @(posedge clk);
        #1;
        m_d2 = m_d1;
        m_d1 = raw_of(m_mode, m_pos);
        m_mode = nm; m_pos = np; m_err = ne;
        m_vs_prev = vs; m_hs_prev = hs;
        check_all();
        smp++;
        if (lb1_rd_en) begin n_lb1++; if (first_lb1 < 0) first_lb1 = smp; end
        if (out_valid) begin n_ov++;  if (first_ov < 0)  first_ov  = smp; end
        if (lb2_rd_en)   n_lb2++;
        if (top_edge)    n_top++;
        if (bottom_edge) n_bot++;
        if (left_edge)   n_left++;
        if (right_edge)  n_right++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pre_img_vsync = 1'b0; pre_img_hsync = 1'b0;
        #1;
        chk("rst_counters", {state, h_cnt, v_cnt}, 0);
        chk("rst_flags", {lb1_rd_en, lb2_rd_en, out_vsync, out_hsync, out_valid,
                          top_edge, bottom_edge, left_edge, right_edge, frame_err}, 0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        smp = 0;
        clear_tally();
        #1;
        do_reset();

        // Arm, lock to vsync then hsync.
        cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("idle_hold", state, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("to_armed", state, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0); chk("to_wait_line", state, 2);
        clear_tally();
        cyc(1'b1, 1'b0, 1'b1, 1'b0); chk("to_run", state, 3);
        chk("run_h0", h_cnt, 0); chk("run_v0", v_cnt, 0);

        // Full undisturbed frame.
        repeat (HT * VT - 1) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("frame_lb1", n_lb1, 32);
        chk("frame_lb2", n_lb2, 24);
        chk("frame_out_valid", n_ov, 32);
        chk("valid_lag", first_ov - first_lb1, 2);
        chk("frame_top", n_top, 8);
        chk("frame_bottom", n_bot, 8);
        chk("frame_left", n_left, 4);
        chk("frame_right", n_right, 4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0); chk("eof_armed", state, 1);

        // Mid-frame vsync raises the sticky error; err_clr drops it.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3 * HT + 5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_err_h", h_cnt, 5); chk("pre_err_v", v_cnt, 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("err_state", state, 2); chk("err_h", h_cnt, 0);
        chk("err_v", v_cnt, 0);     chk("err_set", frame_err, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1); chk("err_clr", frame_err, 0);

        // Vsync coinciding with end of frame is a clean resync.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (HT * VT - 1) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("eof_h", h_cnt, HT - 1); chk("eof_v", v_cnt, VT - 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("eof_vs_state", state, 2); chk("eof_vs_noerr", frame_err, 0);

        // Dropping enable at v=1 lets the frame finish before going idle.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (HT) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("drop_at_v1", v_cnt, 1);
        repeat (HT * VT - 1 - HT) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_still_run", state, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0); chk("drop_idle", state, 0);

        // Asynchronous reset in the middle of a frame.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_run", state, 3);
        do_reset();

        // Error set and clear in the same cycle: set wins.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1); chk("set_wins", frame_err, 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1); chk("clr_after", frame_err, 0);

        // Random sync/enable/clear traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 59) != 0),
                ($urandom_range(0, 119) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
